// File: rtl/demux4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : demux4_tdm
// Brief    : 1-to-4 time-division demultiplexer; optional framing check via
//            SOF_CHECK_EN (sticky err on early/missing sof).
// Revision : 1.0 - initial release
// ============================================================================
module demux4_tdm #(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     x,
  input  logic             x_valid,
  input  logic             sof,
  output logic [W-1:0]     f0,
  output logic [W-1:0]     f1,
  output logic [W-1:0]     f2,
  output logic [W-1:0]     f3,
  output logic             frame_valid,
  output logic [1:0]       sel,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err
);

  localparam logic [1:0] SLOT_0 = 2'd0;
  localparam logic [1:0] SLOT_1 = 2'd1;
  localparam logic [1:0] SLOT_2 = 2'd2;
  localparam logic [1:0] SLOT_3 = 2'd3;

  logic [1:0]       sel_q, sel_d;
  logic [W-1:0]     s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [W-1:0]     f0_q, f0_d, f1_q, f1_d, f2_q, f2_d, f3_q, f3_d;
  logic             frame_valid_q, frame_valid_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]       slot;

  // sof forces slot 0, which also realigns a stream that drifted mid-frame
  always_comb begin
    slot = sof ? SLOT_0 : sel_q;
  end

  always_comb begin
    sel_d         = sel_q;
    s0_d          = s0_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    f0_d          = f0_q;
    f1_d          = f1_q;
    f2_d          = f2_q;
    f3_d          = f3_q;
    frame_valid_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (x_valid) begin
      case (slot)
        SLOT_0: begin
          s0_d  = x;
          sel_d = SLOT_1;
        end
        SLOT_1: begin
          s1_d  = x;
          sel_d = SLOT_2;
        end
        SLOT_2: begin
          s2_d  = x;
          sel_d = SLOT_3;
        end
        default: begin
          f0_d          = s0_q;
          f1_d          = s1_q;
          f2_d          = s2_q;
          f3_d          = x;
          sel_d         = SLOT_0;
          frame_valid_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q         <= SLOT_0;
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      f0_q          <= '0;
      f1_q          <= '0;
      f2_q          <= '0;
      f3_q          <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      sel_q         <= sel_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      f0_q          <= f0_d;
      f1_q          <= f1_d;
      f2_q          <= f2_d;
      f3_q          <= f3_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef SOF_CHECK_EN
  logic err_q, err_d;
  logic seen_frame_q, seen_frame_d;
  logic early_sof, missing_sof;

  // Missing sof only counts once a frame has completed since reset
  always_comb begin
    early_sof    = x_valid && sof && (sel_q != SLOT_0);
    missing_sof  = x_valid && !sof && (sel_q == SLOT_0) && seen_frame_q;
    err_d        = err_q || early_sof || missing_sof;
    seen_frame_d = seen_frame_q || (x_valid && (slot == SLOT_3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q        <= 1'b0;
      seen_frame_q <= 1'b0;
    end else begin
      err_q        <= err_d;
      seen_frame_q <= seen_frame_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign f0          = f0_q;
  assign f1          = f1_q;
  assign f2          = f2_q;
  assign f3          = f3_q;
  assign frame_valid = frame_valid_q;
  assign sel         = sel_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux4_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux4_tdm
// Brief    : Self-checking bench for demux4_tdm (W=4): vector table, directed
//            corner sequences and random traffic against a frame-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux4_tdm;

  logic       clk = 1'b0;
  logic       rst, x_valid, sof;
  logic [3:0] x;
  logic [3:0] f0, f1, f2, f3;
  logic       frame_valid, err;
  logic [1:0] sel;
  logic [7:0] frame_cnt;

  int checks = 0;
  int passed = 0;

  demux4_tdm #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sof(sof),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3), .frame_valid(frame_valid),
    .sel(sel), .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Model: the partial frame is a queue of accepted slots; its length is the slot index.
  logic [3:0] part[$];
  logic [3:0] mf[4];
  int         frames;
  bit         mfv, merr;
`ifdef SOF_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic model_step(input bit r, input bit v, input bit s, input logic [3:0] d);
    if (r) begin
      part.delete();
      for (int i = 0; i < 4; i++) mf[i] = 4'h0;
      frames = 0; mfv = 1'b0; merr = 1'b0;
    end else begin
      mfv = 1'b0;
      if (v) begin
        if (CHK && ((s && part.size() != 0) || (!s && part.size() == 0 && frames > 0)))
          merr = 1'b1;
        if (s) part.delete();
        part.push_back(d);
        if (part.size() == 4) begin
          for (int i = 0; i < 4; i++) mf[i] = part[i];
          frames++;
          mfv = 1'b1;
          part.delete();
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One clock: drive, model, then compare every output against the model.
  task automatic cycle(input bit r, input bit v, input bit s, input logic [3:0] d);
    logic [31:0] got, exp;
    rst = r; x_valid = v; sof = s; x = d;
    @(posedge clk);
    model_step(r, v, s, d);
    #1;
    got = {f0, f1, f2, f3, 3'b0, frame_valid, 2'b0, sel, frame_cnt};
    exp = {mf[0], mf[1], mf[2], mf[3], 3'b0, mfv, 2'b0, 2'(part.size()), 8'(frames)};
    check("model_outputs", {32'h0, got}, {32'h0, exp});
    check("model_err", {63'h0, err}, {63'h0, merr});
  endtask

  typedef struct {
    bit r, v, s;
    logic [3:0] d;
    logic [15:0] ef;
    bit efv;
    logic [1:0] esel;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[12];
  int   pulses;

  initial begin
    // T1 reset then idle, T2 single frame A,B,C,D followed by idle
    tbl[0]  = '{1, 0, 0, 4'h0, 16'h0000, 0, 2'd0, 8'd0};
    tbl[1]  = '{1, 0, 0, 4'h0, 16'h0000, 0, 2'd0, 8'd0};
    tbl[2]  = '{0, 0, 1, 4'h5, 16'h0000, 0, 2'd0, 8'd0};
    tbl[3]  = '{0, 0, 0, 4'h0, 16'h0000, 0, 2'd0, 8'd0};
    tbl[4]  = '{0, 0, 0, 4'h0, 16'h0000, 0, 2'd0, 8'd0};
    tbl[5]  = '{0, 1, 1, 4'hA, 16'h0000, 0, 2'd1, 8'd0};
    tbl[6]  = '{0, 1, 0, 4'hB, 16'h0000, 0, 2'd2, 8'd0};
    tbl[7]  = '{0, 1, 0, 4'hC, 16'h0000, 0, 2'd3, 8'd0};
    tbl[8]  = '{0, 1, 0, 4'hD, 16'hABCD, 1, 2'd0, 8'd1};
    tbl[9]  = '{0, 0, 0, 4'h0, 16'hABCD, 0, 2'd0, 8'd1};
    tbl[10] = '{0, 0, 1, 4'h7, 16'hABCD, 0, 2'd0, 8'd1};
    tbl[11] = '{0, 0, 0, 4'h0, 16'hABCD, 0, 2'd0, 8'd1};

    rst = 1'b1; x_valid = 1'b0; sof = 1'b0; x = 4'h0;
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d", i),
            {35'h0, f0, f1, f2, f3, frame_valid, sel, frame_cnt, err},
            {35'h0, tbl[i].ef, tbl[i].efv, tbl[i].esel, tbl[i].ecnt, 1'b0});
    end

    // T3: bubbles between slots, then a back-to-back frame
    pulses = 0;
    cycle(0, 1, 1, 4'h1); pulses += int'(frame_valid);
    cycle(0, 0, 0, 4'hF); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'h2); pulses += int'(frame_valid);
    cycle(0, 0, 1, 4'hF); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'h3); pulses += int'(frame_valid);
    cycle(0, 0, 0, 4'hF); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'h4); pulses += int'(frame_valid);
    check("t3_first", {48'h0, f0, f1, f2, f3}, 64'h1234);
    cycle(0, 1, 1, 4'h5); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'h6); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'h7); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'h8); pulses += int'(frame_valid);
    cycle(0, 0, 0, 4'h0); pulses += int'(frame_valid);
    check("t3_second", {48'h0, f0, f1, f2, f3}, 64'h5678);
    check("t3_pulses", 64'(pulses), 64'd2);
    check("t3_cnt", {56'h0, frame_cnt}, 64'd3);

    // T4: resync after two slots
    pulses = 0;
    cycle(0, 1, 1, 4'h9); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'hA); pulses += int'(frame_valid);
    cycle(0, 1, 1, 4'h1); pulses += int'(frame_valid);
    check("t4_err", {63'h0, err}, {63'h0, CHK});
    cycle(0, 1, 0, 4'h2); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'h3); pulses += int'(frame_valid);
    check("t4_no_early_pulse", 64'(pulses), 64'd0);
    cycle(0, 1, 0, 4'h4);
    check("t4_frame", {48'h0, f0, f1, f2, f3, 6'h0, frame_valid, 8'h0, frame_cnt},
          {48'h0, 16'h1234, 6'h0, 1'b1, 8'h0, 8'd4});

    // T5: reset mid-frame, then a clean frame
    cycle(0, 1, 1, 4'hE);
    cycle(0, 1, 0, 4'hE);
    cycle(1, 1, 0, 4'hE);
    pulses = 0;
    cycle(0, 1, 1, 4'h5); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'h6); pulses += int'(frame_valid);
    cycle(0, 1, 0, 4'h7); pulses += int'(frame_valid);
    check("t5_no_partial_pulse", 64'(pulses), 64'd0);
    cycle(0, 1, 0, 4'h8);
    check("t5_frame", {40'h0, f0, f1, f2, f3, frame_cnt}, {40'h0, 16'h5678, 8'd1});
    check("t5_err", {63'h0, err}, 64'd0);

    // Random traffic: gaps, stray/missing sof, occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0, 4'($urandom));
    end

    // T6: frame counter wrap
    cycle(1, 0, 0, 4'h0);
    for (int n = 1; n <= 257; n++) begin
      cycle(0, 1, 1, 4'($urandom));
      cycle(0, 1, 0, 4'($urandom));
      cycle(0, 1, 0, 4'($urandom));
      cycle(0, 1, 0, 4'($urandom));
      if (n == 255) check("t6_cnt255", {56'h0, frame_cnt}, 64'd255);
      if (n == 256) check("t6_wrap", {56'h0, frame_cnt}, 64'd0);
      if (n == 257) check("t6_after_wrap", {56'h0, frame_cnt}, 64'd1);
    end
    check("t6_err", {63'h0, err}, 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
